secded_encoder_seq: RTL and testbench
=====================================

// Module: secded_encoder_seq
// PURPOSE
//  - Sequential SECDED(72,64) encoder: accepts 64-bit words over valid/ready, emits 72-bit codewords.
//  - Codeword = {SECDED_ECC_pkg::mega_xor(data[63:0]), data[63:0]}; parity in [71:64].
//  - Sits on the write side of ECC-protected storage/links; its output feeds the sequential SECDED decoder.
//  - Elastic: an internal FIFO decouples input from output backpressure, sustaining 1 word/cycle.
// PARAMETERS
//  - FIFO_DEPTH  2   codeword buffer entries; power of two, >=2
//  - CNT_W       32  width of the accepted-word counter
// PORTS
//  - clk         in   1           clock, all state on rising edge
//  - rst_n       in   1           async active-low reset
//  - in_valid    in   1           data_in valid
//  - in_ready    out  1           encoder can accept data_in this cycle
//  - data_in     in   64          payload
//  - out_valid   out  1           data_out holds a valid codeword
//  - out_ready   in   1           sink accepts data_out this cycle
//  - data_out    out  72          codeword {parity[7:0], data[63:0]}
//  - word_count  out  CNT_W       words accepted since reset
// BEHAVIOUR
//  - Reset (async assert, sync release): FIFO empty; out_valid=0, in_ready=1, data_out=0, word_count=0.
//  - Accept when in_valid&&in_ready; emit when out_valid&&out_ready. All else holds state.
//  - Parity is computed combinationally from data_in; the full 72-bit codeword is written into the FIFO.
//  - Latency: word accepted at edge N shows on data_out/out_valid after edge N (visible cycle N+1) if FIFO was empty.
//  - in_ready = (occupancy < FIFO_DEPTH), driven from registered occupancy only (no comb path from out_ready).
//  - out_valid = (occupancy != 0); data_out = head entry, 0 when empty.
//  - Full + simultaneous pop: in_ready stays 0 that cycle (registered); accept resumes next cycle.
//  - Simultaneous push and pop when not full/empty: occupancy unchanged, order preserved.
//  - Pop when empty / push when full impossible by construction; inputs ignored.
//  - Stability: while out_valid && !out_ready, data_out must not change.
//  - Pointers wrap modulo FIFO_DEPTH; occupancy width clog2(FIFO_DEPTH)+1.
//  - word_count += 1 per accept; wraps 2^CNT_W-1 -> 0 silently.
//  - Reset mid-operation: all buffered words discarded, outputs return to reset values immediately.
// CONFIGURATION
//  - SECDED_ERR_INJECT_EN defined: adds ports inj_valid (in,1) and inj_mask (in,72).
//    When an accept occurs with inj_valid=1, the stored codeword = computed codeword ^ inj_mask.
//    Injection applies to that word only; inj_valid ignored when no accept. word_count unaffected.
//  - Not defined: ports absent, codewords always clean; no injection logic synthesized.
// TESTING
//  - Reset: rst_n=0 mid-stream with 2 words buffered -> out_valid=0, in_ready=1, data_out=0, word_count=0.
//  - data_in=64'h0, out_ready=1 -> data_out=72'h0 one cycle later; word_count=1.
//  - Sweep data_in=64'h1<<k, k=0..63 -> data_out[71:64]==mega_xor(data), data_out[63:0]==data.
//  - out_ready=0, push 3 words (DEPTH=2) -> in_ready=0 after 2nd; 3rd held; release -> 3 words in order.
//  - Random valid/ready 10k words looped into sequential decoder -> no error flags, data matches, count=10000.
//  - SECDED_ERR_INJECT_EN: mask 72'h1 -> decoder single_error=1, corrected data; mask 72'h3 -> double_error=1.

Source files
------------

// File: rtl/SECDED_ECC_pkg.sv
// SECDED(72,64) parity function shared by encoder and decoder.
// parity[6:0]: Hamming check bits over positions 1..71; parity[7]: overall parity.
package SECDED_ECC_pkg;

    // Data bit k occupies the k-th non-power-of-two codeword position
    // (3,5,6,7,9,...,71); check bit j covers positions with bit j set.
    function automatic logic [63:0] check_mask(input logic [2:0] j);
        logic [63:0] mask;
        logic [5:0]  k;
        logic [6:0]  pos;
        mask = '0;
        k    = '0;
        for (int p = 1; p < 72; p++) begin
            pos = 7'(p);
            if ((pos & (pos - 7'd1)) != 7'd0) begin
                mask[k] = pos[j];
                k       = k + 6'd1;
            end
        end
        return mask;
    endfunction

    function automatic logic [7:0] mega_xor(input logic [63:0] d);
        logic [7:0] p;
        p = '0;
        for (int j = 0; j < 7; j++) begin
            p[j] = ^(d & check_mask(3'(j)));
        end
        // Overall parity lets the decoder split single from double errors.
        p[7] = (^d) ^ (^p[6:0]);
        return p;
    endfunction

endpackage

// File: rtl/secded_encoder_seq.sv
// Sequential SECDED(72,64) encoder with an elastic codeword FIFO.
// Ports: clk, rst_n (async low), in_valid/in_ready/data_in[63:0] (write side),
//        out_valid/out_ready/data_out[71:0] (codeword side), word_count[CNT_W-1:0].
// Optional macro SECDED_ERR_INJECT_EN adds inj_valid and inj_mask[71:0]:
//        an accepted word with inj_valid=1 is stored as codeword ^ inj_mask.
module secded_encoder_seq #(
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      data_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [71:0]      data_out,
    output logic [CNT_W-1:0] word_count
`ifdef SECDED_ERR_INJECT_EN
    ,
    input  logic             inj_valid,
    input  logic [71:0]      inj_mask
`endif
);
    import SECDED_ECC_pkg::*;

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OW = PW + 1;
    localparam logic [OW-1:0] DEPTH_C = OW'(FIFO_DEPTH);

    logic [71:0]      mem_q [FIFO_DEPTH];
    logic [71:0]      mem_d [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [OW-1:0]    occ_q, occ_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [71:0]      codeword;
    logic             push;
    logic             pop;

    // Handshake flags come from registered occupancy only.
    assign in_ready   = (occ_q < DEPTH_C);
    assign out_valid  = (occ_q != '0);
    assign data_out   = out_valid ? mem_q[rd_ptr_q] : '0;
    assign word_count = cnt_q;

    always_comb begin
        push     = in_valid && in_ready;
        pop      = out_valid && out_ready;
        codeword = {mega_xor(data_in), data_in};
`ifdef SECDED_ERR_INJECT_EN
        if (inj_valid) begin
            codeword = codeword ^ inj_mask;
        end
`endif
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        cnt_d    = cnt_q;
        if (push) begin
            mem_d[wr_ptr_q] = codeword;
            wr_ptr_d        = wr_ptr_q + 1'b1;
            cnt_d           = cnt_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({push, pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_secded_encoder_seq.sv
// Bench for secded_encoder_seq: random and directed traffic
// against a queue model with a position-syndrome Hamming encoder.
module tb_secded_encoder_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] data_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [71:0] data_out;
    logic [31:0] word_count;
`ifdef SECDED_ERR_INJECT_EN
    logic        inj_valid = 1'b0;
    logic [71:0] inj_mask = '0;
`endif

    secded_encoder_seq #(.FIFO_DEPTH(2), .CNT_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .data_in    (data_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .data_out   (data_out),
        .word_count (word_count)
`ifdef SECDED_ERR_INJECT_EN
        ,
        .inj_valid  (inj_valid),
        .inj_mask   (inj_mask)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [71:0] exp_q[$];
    logic [31:0] exp_cnt = '0;

    task automatic check(input string tag, input logic [71:0] obs,
                         input logic [71:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Check bits = XOR of the codeword positions of all set data bits;
    // the extra bit makes the whole codeword even parity.
    function automatic logic [71:0] enc(input logic [63:0] d);
        logic [6:0] syn;
        int k;
        syn = '0;
        k = 0;
        for (int pos = 3; pos < 72; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                if (d[k]) syn = syn ^ 7'(pos);
                k++;
            end
        end
        return {(^d) ^ (^syn), syn, d};
    endfunction

    task automatic cmp_state(input string tag);
        int n;
        n = exp_q.size();
        check({tag, "_ovalid"}, 72'(out_valid), 72'(n != 0));
        check({tag, "_iready"}, 72'(in_ready), 72'(n < 2));
        check({tag, "_dout"}, data_out, (n != 0) ? exp_q[0] : 72'h0);
        check({tag, "_count"}, 72'(word_count), 72'(exp_cnt));
    endtask

    // Called just after a negedge: compare, drive, advance model one edge.
    task automatic step(input string tag, input logic iv,
                        input logic [63:0] d, input logic ordy);
        logic acc, emit;
        cmp_state(tag);
        in_valid  = iv;
        data_in   = d;
        out_ready = ordy;
        acc  = iv && (exp_q.size() < 2);
        emit = ordy && (exp_q.size() != 0);
        if (emit) void'(exp_q.pop_front());
        if (acc) begin
            exp_q.push_back(enc(d));
            exp_cnt++;
        end
        @(negedge clk);
    endtask

    initial begin
        int cyc;
        @(negedge clk);
        check("rst_ovalid", 72'(out_valid), 72'h0);
        check("rst_iready", 72'(in_ready), 72'h1);
        check("rst_dout", data_out, 72'h0);
        check("rst_count", 72'(word_count), 72'h0);
        rst_n = 1'b1;
        @(negedge clk);

        step("zero", 1'b1, 64'h0, 1'b1);
        check("zero_cw", data_out, 72'h0);
        check("zero_cnt", 72'(word_count), 72'h1);
        step("drain0", 1'b0, 64'h0, 1'b1);

        for (int k = 0; k < 64; k++) begin
            step("sweep", 1'b1, 64'h1 << k, 1'b1);
            check("sweep_par", 72'(data_out[71:64]), 72'(enc(64'h1 << k) >> 64));
            check("sweep_data", 72'(data_out[63:0]), 72'(64'h1 << k));
            if (k == 0) check("known_cw1", data_out, 72'h83_0000_0000_0000_0001);
        end
        step("drain1", 1'b0, 64'h0, 1'b1);

        step("bp1", 1'b1, 64'hA1A1_0000_0000_0001, 1'b0);
        step("bp2", 1'b1, 64'hB2B2_0000_0000_0002, 1'b0);
        check("bp_full", 72'(in_ready), 72'h0);
        step("bp3", 1'b1, 64'hC3C3_0000_0000_0003, 1'b0);
        step("bp_pop_full", 1'b1, 64'hC3C3_0000_0000_0003, 1'b1);
        step("bp_resume", 1'b1, 64'hC3C3_0000_0000_0003, 1'b1);
        step("bp_d1", 1'b0, 64'h0, 1'b1);
        step("bp_d2", 1'b0, 64'h0, 1'b1);
        step("bp_d3", 1'b0, 64'h0, 1'b1);

        exp_cnt = '0;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        cyc = 0;
        while (exp_cnt < 10000 && cyc < 60000) begin
            step("rand", ($urandom_range(0, 3) != 0),
                 {$urandom, $urandom}, ($urandom_range(0, 3) != 0));
            cyc++;
        end
        check("rand_count", 72'(word_count), 72'd10000);

        step("mr1", 1'b1, {$urandom, $urandom}, 1'b0);
        step("mr2", 1'b1, {$urandom, $urandom}, 1'b0);
        check("mr_two_buf", 72'(exp_q.size()), 72'd2);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        exp_cnt = '0;
        #1;
        check("mrst_ovalid", 72'(out_valid), 72'h0);
        check("mrst_iready", 72'(in_ready), 72'h1);
        check("mrst_dout", data_out, 72'h0);
        check("mrst_count", 72'(word_count), 72'h0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst", 1'b1, 64'h0123_4567_89AB_CDEF, 1'b1);
        step("post_rst2", 1'b0, 64'h0, 1'b1);
        cmp_state("final");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
